// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: iterative double-dabble, one input bit per clock,
// with a start/done handshake so one instance can be time-shared across several values.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                state, state_next;
    logic [WIDTH-1:0]      bin_reg, bin_next;
    logic [4*DIGITS-1:0]   scratch, scratch_next, adjusted;
    logic                  ovf, ovf_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [4*DIGITS-1:0]   bcd_next;
    logic                  overflow_next;

    // Add-3 correction on every digit in parallel; a 4-bit digit <= 9 stays <= 12 here.
    always_comb begin
        adjusted = scratch;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_next    = state;
        bin_next      = bin_reg;
        scratch_next  = scratch;
        ovf_next      = ovf;
        cnt_next      = cnt;
        bcd_next      = bcd_out;
        overflow_next = overflow;
        busy          = 1'b0;
        done          = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    bin_next     = bin_in;
                    scratch_next = '0;
                    ovf_next     = 1'b0;
                    cnt_next     = CW'(WIDTH - 1);
                    state_next   = SHIFT;
                end
            end

            SHIFT: begin
                busy         = 1'b1;
                scratch_next = {adjusted[4*DIGITS-2:0], bin_reg[WIDTH-1]};
                bin_next     = {bin_reg[WIDTH-2:0], 1'b0};
                // A bit leaving the top digit means the value no longer fits in DIGITS digits.
                ovf_next     = ovf | adjusted[4*DIGITS-1];
                if (cnt == '0) begin
                    state_next    = DONE;
                    bcd_next      = scratch_next;
                    overflow_next = ovf_next;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
                if (start) begin
                    bin_next     = bin_in;
                    scratch_next = '0;
                    ovf_next     = 1'b0;
                    cnt_next     = CW'(WIDTH - 1);
                    state_next   = SHIFT;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            bin_reg  <= '0;
            scratch  <= '0;
            ovf      <= 1'b0;
            cnt      <= '0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            bin_reg  <= bin_next;
            scratch  <= scratch_next;
            ovf      <= ovf_next;
            cnt      <= cnt_next;
            bcd_out  <= bcd_next;
            overflow <= overflow_next;
        end
    end

endmodule
